// File: rtl/lane_assist_ctrl.sv
// lane_assist_ctrl
//   Lane-keeping assist controller. A departure input must be held for
//   DEBOUNCE_CYC consecutive edges before a correction starts. The correction
//   ramps its strength by RAMP_STEP per cycle, saturating at full scale. When
//   the correction ends the controller rests in COOLDOWN for COOLDOWN_CYC
//   cycles. A correction lasting MAX_ASSIST_CYC cycles latches a fault and
//   parks the controller in DISABLED until reset.
//
// Ports
//   CLK              clock, rising edge
//   RST              asynchronous, active-high reset
//   assist_right     vehicle departing the right side of the lane
//   assist_left      vehicle departing the left side of the lane
//   assist_disable   driver disables lane assist (level, highest priority)
//   driver_override  intentional lane change, suppresses correction
//   lane[2:0]        010 idle/armed, 001 correcting right, 100 correcting left,
//                    000 disabled
//   strength         correction magnitude, nonzero only while correcting
//   fault            sticky correction-timeout flag
module lane_assist_ctrl #(
  parameter int unsigned DEBOUNCE_CYC   = 4,
  parameter int unsigned COOLDOWN_CYC   = 8,
  parameter int unsigned MAX_ASSIST_CYC = 1000,
  parameter int unsigned LEVEL_W        = 4,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               assist_right,
  input  logic               assist_left,
  input  logic               assist_disable,
  input  logic               driver_override,
  output logic [2:0]         lane,
  output logic [LEVEL_W-1:0] strength,
  output logic               fault
);

  // Counter widths cover the full parameter value.
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned CD_W  = $clog2(COOLDOWN_CYC + 1);
  localparam int unsigned AS_W  = $clog2(MAX_ASSIST_CYC + 1);
  localparam int unsigned SUM_W = LEVEL_W + 1;

  localparam logic [LEVEL_W-1:0] MAX_STRENGTH = '1;
  localparam logic [LEVEL_W-1:0] STEP         = LEVEL_W'(RAMP_STEP);

  localparam logic [2:0] LANE_IDLE  = 3'b010;
  localparam logic [2:0] LANE_RIGHT = 3'b001;
  localparam logic [2:0] LANE_LEFT  = 3'b100;
  localparam logic [2:0] LANE_OFF   = 3'b000;

  typedef enum logic [2:0] {
    ARMED    = 3'd0,
    PEND_R   = 3'd1,
    PEND_L   = 3'd2,
    ASSIST_R = 3'd3,
    ASSIST_L = 3'd4,
    COOLDOWN = 3'd5,
    DISABLED = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic [AS_W-1:0]    as_cnt_q, as_cnt_d;
  logic [LEVEL_W-1:0] strength_q, strength_d;
  logic               fault_q, fault_d;
  logic [2:0]         lane_q, lane_d;

  // A direction qualifies only when it alone is high and no override is active.
  logic          sel_r, sel_l;
  logic [SUM_W-1:0] ramp_sum;
  logic [LEVEL_W-1:0] ramp_sat;

  assign sel_r = assist_right & ~assist_left & ~driver_override;
  assign sel_l = assist_left & ~assist_right & ~driver_override;

  // Saturating ramp: the extra sum bit flags overflow past full scale.
  assign ramp_sum = {1'b0, strength_q} + SUM_W'(RAMP_STEP);
  assign ramp_sat = ramp_sum[LEVEL_W] ? MAX_STRENGTH : ramp_sum[LEVEL_W-1:0];

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARMED;
      db_cnt_q   <= '0;
      cd_cnt_q   <= '0;
      as_cnt_q   <= '0;
      strength_q <= '0;
      fault_q    <= 1'b0;
      lane_q     <= LANE_IDLE;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      as_cnt_q   <= as_cnt_d;
      strength_q <= strength_d;
      fault_q    <= fault_d;
      lane_q     <= lane_d;
    end
  end

  // Next-state, counter and strength logic.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    as_cnt_d   = as_cnt_q;
    strength_d = strength_q;
    fault_d    = fault_q;

    if (assist_disable) begin
      state_d    = DISABLED;
      strength_d = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          strength_d = '0;
          if (sel_r) begin
            if (DEBOUNCE_CYC == 1) begin
              state_d    = ASSIST_R;
              strength_d = STEP;
            end else begin
              state_d = PEND_R;
            end
          end else if (sel_l) begin
            if (DEBOUNCE_CYC == 1) begin
              state_d    = ASSIST_L;
              strength_d = STEP;
            end else begin
              state_d = PEND_L;
            end
          end
        end

        PEND_R, PEND_L: begin
          if ((state_q == PEND_R && sel_r) || (state_q == PEND_L && sel_l)) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
              state_d    = (state_q == PEND_R) ? ASSIST_R : ASSIST_L;
              strength_d = STEP;
            end else begin
              db_cnt_d = db_cnt_q + DB_W'(1);
            end
          end else begin
            state_d = ARMED;
          end
        end

        ASSIST_R, ASSIST_L: begin
          if ((state_q == ASSIST_R && sel_r) || (state_q == ASSIST_L && sel_l)) begin
            // Counter holds the number of ASSIST cycles already completed.
            if (as_cnt_q == AS_W'(MAX_ASSIST_CYC - 1)) begin
              state_d    = DISABLED;
              fault_d    = 1'b1;
              strength_d = '0;
            end else begin
              as_cnt_d   = as_cnt_q + AS_W'(1);
              strength_d = ramp_sat;
            end
          end else begin
            // Release, reversal or override all end the correction.
            state_d    = COOLDOWN;
            strength_d = '0;
          end
        end

        COOLDOWN: begin
          strength_d = '0;
          if (cd_cnt_q == CD_W'(COOLDOWN_CYC - 1)) begin
            state_d = ARMED;
          end else begin
            cd_cnt_d = cd_cnt_q + CD_W'(1);
          end
        end

        DISABLED: begin
          strength_d = '0;
          if (!fault_q) begin
            state_d = ARMED;
          end
        end

        default: begin
          state_d    = ARMED;
          strength_d = '0;
        end
      endcase
    end

    // Every state change restarts all counters; entering a pending state
    // already accounts for the first qualifying sample.
    if (state_d != state_q) begin
      db_cnt_d = '0;
      cd_cnt_d = '0;
      as_cnt_d = '0;
      if (state_d == PEND_R || state_d == PEND_L) begin
        db_cnt_d = DB_W'(1);
      end
    end
  end

  // Lane status decoded from the upcoming state so it registers with it.
  always_comb begin
    lane_d = LANE_IDLE;
    unique case (state_d)
      ASSIST_R: lane_d = LANE_RIGHT;
      ASSIST_L: lane_d = LANE_LEFT;
      DISABLED: lane_d = LANE_OFF;
      default:  lane_d = LANE_IDLE;
    endcase
  end

  assign lane     = lane_q;
  assign strength = strength_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_lane_assist_ctrl.sv
module tb_lane_assist_ctrl;

  localparam int DEB  = 4;
  localparam int CD   = 8;
  localparam int MAXA = 20;
  localparam int STEP = 1;
  localparam int FULL = 15;

  // Model phases: a correction is either waiting, running, resting or off.
  localparam int P_IDLE = 0;
  localparam int P_ACT  = 1;
  localparam int P_COOL = 2;
  localparam int P_OFF  = 3;

  logic       CLK;
  logic       RST;
  logic       assist_right;
  logic       assist_left;
  logic       assist_disable;
  logic       driver_override;
  logic [2:0] lane;
  logic [3:0] strength;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  lane_assist_ctrl #(
    .DEBOUNCE_CYC  (DEB),
    .COOLDOWN_CYC  (CD),
    .MAX_ASSIST_CYC(MAXA),
    .LEVEL_W       (4),
    .RAMP_STEP     (STEP)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .assist_right   (assist_right),
    .assist_left    (assist_left),
    .assist_disable (assist_disable),
    .driver_override(driver_override),
    .lane           (lane),
    .strength       (strength),
    .fault          (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_phase  = P_IDLE;
  int         m_dir    = 0;   // 1 right, 2 left
  int         m_streak = 0;   // consecutive qualifying samples in one direction
  int         m_act    = 0;   // correction cycles so far
  int         m_cool   = 0;
  int         tmp;
  bit         q_r, q_l;
  logic [2:0] m_lane   = 3'b010;
  logic [3:0] m_str    = 4'd0;
  logic       m_fault  = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = P_IDLE; m_streak = 0; m_act = 0; m_cool = 0;
      m_str = 4'd0; m_fault = 1'b0;
    end else begin
      q_r = assist_right && !assist_left && !driver_override;
      q_l = assist_left && !assist_right && !driver_override;
      if (assist_disable) begin
        m_phase = P_OFF; m_str = 4'd0; m_streak = 0;
      end else begin
        case (m_phase)
          P_IDLE: begin
            if ((q_r || q_l) && (m_streak == 0 || (q_r ? 1 : 2) == m_dir)) begin
              m_dir = q_r ? 1 : 2;
              m_streak++;
            end else begin
              m_streak = 0;
            end
            if (m_streak == DEB) begin
              m_phase = P_ACT; m_act = 1; m_str = 4'(STEP); m_streak = 0;
            end
          end
          P_ACT: begin
            if ((m_dir == 1 && q_r) || (m_dir == 2 && q_l)) begin
              if (m_act == MAXA) begin
                m_phase = P_OFF; m_fault = 1'b1; m_str = 4'd0;
              end else begin
                m_act++;
                tmp = int'(m_str) + STEP;
                m_str = (tmp > FULL) ? 4'(FULL) : 4'(tmp);
              end
            end else begin
              m_phase = P_COOL; m_cool = 0; m_str = 4'd0;
            end
          end
          P_COOL: begin
            m_cool++;
            if (m_cool == CD) m_phase = P_IDLE;
          end
          default: begin
            if (!m_fault) m_phase = P_IDLE;
          end
        endcase
      end
    end
    case (m_phase)
      P_ACT:   m_lane = (m_dir == 1) ? 3'b001 : 3'b100;
      P_OFF:   m_lane = 3'b000;
      default: m_lane = 3'b010;
    endcase
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("model_lane", 32'(lane), 32'(m_lane));
    chk("model_strength", 32'(strength), 32'(m_str));
    chk("model_fault", 32'(fault), 32'(m_fault));
  end

  // Apply one input pattern for n rising edges; returns on a falling edge.
  task automatic run(input logic r, input logic l, input logic dis, input logic ovr, input int n);
    assist_right = r; assist_left = l; assist_disable = dis; driver_override = ovr;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    assist_right = 0; assist_left = 0; assist_disable = 0; driver_override = 0;
    #2 RST = 1'b1;
    #1;
    chk("rst_async_lane", 32'(lane), 32'(3'b010));
    chk("rst_async_strength", 32'(strength), 32'd0);
    chk("rst_async_fault", 32'(fault), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Held right departure: 3 edges idle, assist on the 4th, ramp to 15.
    run(1, 0, 0, 0, 3);  chk("deb_hold3_lane", 32'(lane), 32'(3'b010));
    run(1, 0, 0, 0, 1);  chk("deb_edge4_lane", 32'(lane), 32'(3'b001));
                         chk("ramp_first", 32'(strength), 32'd1);
    run(1, 0, 0, 0, 1);  chk("ramp_second", 32'(strength), 32'd2);
    run(1, 0, 0, 0, 13); chk("ramp_full", 32'(strength), 32'd15);
    run(1, 0, 0, 0, 3);  chk("ramp_saturate", 32'(strength), 32'd15);
    run(0, 0, 0, 0, 1);  chk("release_lane", 32'(lane), 32'(3'b010));
                         chk("release_strength", 32'(strength), 32'd0);
    run(0, 0, 0, 0, 10);

    // Interrupted debounce restarts from scratch.
    run(1, 0, 0, 0, 3);
    run(0, 0, 0, 0, 1);
    run(1, 0, 0, 0, 3);  chk("deb_restart_idle", 32'(lane), 32'(3'b010));
    run(1, 0, 0, 0, 1);  chk("deb_restart_assist", 32'(lane), 32'(3'b001));
    run(0, 0, 0, 0, 10);

    // Left correction, cooldown ignores a new departure for 8 cycles.
    run(0, 1, 0, 0, 4);  chk("left_lane", 32'(lane), 32'(3'b100));
    run(0, 0, 0, 0, 1);  chk("left_release", 32'(lane), 32'(3'b010));
    run(0, 1, 0, 0, 8);  chk("cool_ignore", 32'(lane), 32'(3'b010));
    run(0, 1, 0, 0, 3);  chk("cool_deb3", 32'(lane), 32'(3'b010));
    run(0, 1, 0, 0, 1);  chk("cool_deb4", 32'(lane), 32'(3'b100));
    run(0, 1, 0, 1, 1);  chk("ovr_ends_assist", 32'(lane), 32'(3'b010));
    run(0, 0, 0, 0, 9);

    // Both departures or override never start a correction.
    run(1, 1, 0, 0, 10); chk("both_high", 32'(lane), 32'(3'b010));
    run(1, 0, 0, 1, 10); chk("override_right", 32'(lane), 32'(3'b010));
    run(0, 0, 0, 0, 1);

    // Disable from pending, assisting and cooldown.
    run(1, 0, 0, 0, 2);
    run(1, 0, 1, 0, 1);  chk("dis_pend", 32'(lane), 32'(3'b000));
    run(1, 0, 0, 0, 1);  chk("dis_pend_exit", 32'(lane), 32'(3'b010));
    run(1, 0, 0, 0, 4);  chk("dis_pre_assist", 32'(lane), 32'(3'b001));
    run(1, 0, 1, 0, 1);  chk("dis_assist", 32'(lane), 32'(3'b000));
                         chk("dis_assist_str", 32'(strength), 32'd0);
    run(0, 0, 0, 0, 1);  chk("dis_assist_exit", 32'(lane), 32'(3'b010));
    run(1, 0, 0, 0, 4);
    run(0, 0, 0, 0, 2);
    run(0, 0, 1, 0, 1);  chk("dis_cool", 32'(lane), 32'(3'b000));
    run(0, 0, 0, 0, 1);  chk("dis_cool_exit", 32'(lane), 32'(3'b010));

    // Reset in the middle of a correction acts immediately.
    run(1, 0, 0, 0, 6);  chk("pre_rst_str", 32'(strength), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_lane", 32'(lane), 32'(3'b010));
    chk("mid_rst_strength", 32'(strength), 32'd0);
    @(negedge CLK);
    assist_right = 0;
    RST = 1'b0;

    // Timeout after MAXA correction cycles latches the fault.
    run(1, 0, 0, 0, 23); chk("pre_timeout", 32'(lane), 32'(3'b001));
    run(1, 0, 0, 0, 1);  chk("timeout_lane", 32'(lane), 32'(3'b000));
                         chk("timeout_fault", 32'(fault), 32'd1);
                         chk("timeout_str", 32'(strength), 32'd0);
    run(0, 0, 0, 0, 5);  chk("fault_sticky", 32'(lane), 32'(3'b000));
    run(0, 0, 1, 0, 1);
    run(0, 0, 0, 0, 2);  chk("fault_after_dis", 32'(lane), 32'(3'b000));
    RST = 1'b1;
    #1;
    chk("fault_rst_lane", 32'(lane), 32'(3'b010));
    chk("fault_rst_fault", 32'(fault), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    run(0, 0, 0, 0, 2);  chk("post_rst_lane", 32'(lane), 32'(3'b010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
